// File: rtl/mdio_pkg.sv
// ============================================================================
// mdio_pkg : shared types and constants for the Clause-22 MDIO responder
// Rev 1.0  : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package mdio_pkg;

   typedef enum logic [2:0] {
      S_PRE   = 3'd0,
      S_ST    = 3'd1,
      S_OP    = 3'd2,
      S_PHYAD = 3'd3,
      S_REGAD = 3'd4,
      S_TA    = 3'd5,
      S_DATA  = 3'd6,
      S_SKIP  = 3'd7
   } mdio_state_e;

   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] OP_WRITE = 2'b01;

   localparam int ADDR_W    = 5;
   localparam int DATA_W    = 16;
   localparam int CNT_W     = 6;
   // REGAD + TA + DATA bits still on the wire when the PHY address mismatches
   localparam int SKIP_BITS = ADDR_W + 2 + DATA_W;

endpackage : mdio_pkg

`default_nettype wire

// File: rtl/mdio_edge_sync.sv
// ============================================================================
// mdio_edge_sync : synchronizes MDC/MDIO into clk and emits an MDC rise pulse
// Rev 1.0        : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mdio_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic mdc,
   input  logic mdio_i,
   output logic mdc_rise,
   output logic mdio_bit
);

   logic [SYNC_STAGES-1:0] r_mdc_sync;
   logic [SYNC_STAGES-1:0] r_mdio_sync;
   logic                   r_mdc_prev;
   logic                   r_rise;
   logic                   r_bit;

   // Pulse and data are registered together so the bit is aligned with its edge
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mdc_sync  <= '0;
         r_mdio_sync <= '0;
         r_mdc_prev  <= 1'b0;
         r_rise      <= 1'b0;
         r_bit       <= 1'b0;
      end else begin
         r_mdc_sync  <= {r_mdc_sync[SYNC_STAGES-2:0], mdc};
         r_mdio_sync <= {r_mdio_sync[SYNC_STAGES-2:0], mdio_i};
         r_mdc_prev  <= r_mdc_sync[SYNC_STAGES-1];
         r_rise      <= r_mdc_sync[SYNC_STAGES-1] & ~r_mdc_prev;
         r_bit       <= r_mdio_sync[SYNC_STAGES-1];
      end
   end

   assign mdc_rise = r_rise;
   assign mdio_bit = r_bit;

endmodule : mdio_edge_sync

`default_nettype wire

// File: rtl/mdio_responder.sv
// ============================================================================
// mdio_responder : Clause-22 MDIO PHY-side responder with register strobe port
//                  Option MDIO_PREAMBLE_SUPPRESS_EN enables preamble suppression
// Rev 1.0        : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mdio_responder
   import mdio_pkg::*;
#(
   parameter logic [ADDR_W-1:0] PHY_ADDR    = 5'd1,
   parameter int                PRE_LEN     = 32,
   parameter int                SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mdc,
   input  logic              mdio_i,
   output logic              mdio_o,
   output logic              mdio_t,
   output logic [ADDR_W-1:0] reg_addr,
   output logic              reg_rd,
   input  logic [DATA_W-1:0] reg_rdata,
   output logic              reg_wr,
   output logic [DATA_W-1:0] reg_wdata,
   output logic              frame_err
);

   localparam logic [CNT_W-1:0] c_PRE_LEN  = CNT_W'(PRE_LEN);
   localparam logic [4:0]       c_SKIP_END = 5'(SKIP_BITS - 1);

   logic w_rise;
   logic w_bit;

   mdio_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .rst      (rst),
      .mdc      (mdc),
      .mdio_i   (mdio_i),
      .mdc_rise (w_rise),
      .mdio_bit (w_bit)
   );

   mdio_state_e       r_state,    w_state;
   logic [CNT_W-1:0]  r_pre_cnt,  w_pre_cnt;
   logic [4:0]        r_bit_cnt,  w_bit_cnt;
   logic [DATA_W-1:0] r_rx_shift, w_rx_shift;
   logic [DATA_W-1:0] r_tx_shift, w_tx_shift;
   logic              r_is_read,  w_is_read;
   logic              r_mdio_o,   w_mdio_o;
   logic              r_mdio_t,   w_mdio_t;
   logic [ADDR_W-1:0] r_reg_addr, w_reg_addr;
   logic [DATA_W-1:0] r_reg_wdata, w_reg_wdata;
   logic              r_reg_rd,   w_reg_rd;
   logic              r_reg_wr,   w_reg_wr;
   logic              r_frame_err, w_frame_err;
   logic [DATA_W-1:0] w_rx_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_PRE;
         r_pre_cnt   <= '0;
         r_bit_cnt   <= '0;
         r_rx_shift  <= '0;
         r_tx_shift  <= '0;
         r_is_read   <= 1'b0;
         r_mdio_o    <= 1'b0;
         r_mdio_t    <= 1'b1;
         r_reg_addr  <= '0;
         r_reg_wdata <= '0;
         r_reg_rd    <= 1'b0;
         r_reg_wr    <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_pre_cnt   <= w_pre_cnt;
         r_bit_cnt   <= w_bit_cnt;
         r_rx_shift  <= w_rx_shift;
         r_tx_shift  <= w_tx_shift;
         r_is_read   <= w_is_read;
         r_mdio_o    <= w_mdio_o;
         r_mdio_t    <= w_mdio_t;
         r_reg_addr  <= w_reg_addr;
         r_reg_wdata <= w_reg_wdata;
         r_reg_rd    <= w_reg_rd;
         r_reg_wr    <= w_reg_wr;
         r_frame_err <= w_frame_err;
      end
   end

   always_comb begin
      w_state     = r_state;
      w_pre_cnt   = r_pre_cnt;
      w_bit_cnt   = r_bit_cnt;
      w_rx_shift  = r_rx_shift;
      w_tx_shift  = r_tx_shift;
      w_is_read   = r_is_read;
      w_mdio_o    = r_mdio_o;
      w_mdio_t    = r_mdio_t;
      w_reg_addr  = r_reg_addr;
      w_reg_wdata = r_reg_wdata;
      w_reg_rd    = 1'b0;
      w_reg_wr    = 1'b0;
      w_frame_err = 1'b0;
      w_rx_next   = {r_rx_shift[DATA_W-2:0], w_bit};

      // Read data arrives the clk after the strobe; MDC is far too slow to collide
      if (r_reg_rd) begin
         w_tx_shift = reg_rdata;
      end

      if (w_rise) begin
         w_bit_cnt  = r_bit_cnt + 5'd1;
         w_rx_shift = w_rx_next;
         case (r_state)
            S_PRE: begin
               w_bit_cnt = '0;
               if (w_bit) begin
                  if (r_pre_cnt < c_PRE_LEN) w_pre_cnt = r_pre_cnt + 1'b1;
               end else if (r_pre_cnt >= c_PRE_LEN) begin
                  w_state = S_ST;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
                  // count survives the frame so the next ST may follow at once
`else
                  w_pre_cnt = '0;
`endif
               end else begin
                  w_pre_cnt = '0;
               end
            end
            S_ST: begin
               w_bit_cnt = '0;
               if (w_bit) begin
                  w_state = S_OP;
               end else begin
                  w_frame_err = 1'b1;
                  w_pre_cnt   = '0;
                  w_state     = S_PRE;
               end
            end
            S_OP: begin
               if (r_bit_cnt == 5'd1) begin
                  w_bit_cnt = '0;
                  if (w_rx_next[1:0] == OP_READ) begin
                     w_is_read = 1'b1;
                     w_state   = S_PHYAD;
                  end else if (w_rx_next[1:0] == OP_WRITE) begin
                     w_is_read = 1'b0;
                     w_state   = S_PHYAD;
                  end else begin
                     w_frame_err = 1'b1;
                     w_pre_cnt   = '0;
                     w_state     = S_PRE;
                  end
               end
            end
            S_PHYAD: begin
               if (r_bit_cnt == 5'd4) begin
                  w_bit_cnt = '0;
                  w_state   = (w_rx_next[ADDR_W-1:0] == PHY_ADDR) ? S_REGAD : S_SKIP;
               end
            end
            S_REGAD: begin
               if (r_bit_cnt == 5'd4) begin
                  w_bit_cnt  = '0;
                  w_reg_addr = w_rx_next[ADDR_W-1:0];
                  w_reg_rd   = r_is_read;
                  w_state    = S_TA;
               end
            end
            S_TA: begin
               if (r_is_read) begin
                  if (r_bit_cnt == 5'd0) begin
                     w_mdio_t = 1'b0;
                     w_mdio_o = 1'b0;
                  end else begin
                     w_mdio_o   = r_tx_shift[DATA_W-1];
                     w_tx_shift = {r_tx_shift[DATA_W-2:0], 1'b0};
                     w_bit_cnt  = '0;
                     w_state    = S_DATA;
                  end
               end else if (w_bit != (r_bit_cnt == 5'd0)) begin
                  w_frame_err = 1'b1;
                  w_pre_cnt   = '0;
                  w_state     = S_PRE;
               end else if (r_bit_cnt == 5'd1) begin
                  w_bit_cnt = '0;
                  w_state   = S_DATA;
               end
            end
            S_DATA: begin
               if (r_bit_cnt == 5'd15) begin
                  w_state  = S_PRE;
                  w_mdio_t = 1'b1;
                  w_mdio_o = 1'b0;
                  if (!r_is_read) begin
                     w_reg_wdata = w_rx_next;
                     w_reg_wr    = 1'b1;
                  end
               end else if (r_is_read) begin
                  w_mdio_o   = r_tx_shift[DATA_W-1];
                  w_tx_shift = {r_tx_shift[DATA_W-2:0], 1'b0};
               end
            end
            S_SKIP: begin
               if (r_bit_cnt == c_SKIP_END) begin
                  w_bit_cnt = '0;
                  w_state   = S_PRE;
               end
            end
            default: begin
               w_state = S_PRE;
            end
         endcase
      end
   end

   assign mdio_o    = r_mdio_o;
   assign mdio_t    = r_mdio_t;
   assign reg_addr  = r_reg_addr;
   assign reg_rd    = r_reg_rd;
   assign reg_wr    = r_reg_wr;
   assign reg_wdata = r_reg_wdata;
   assign frame_err = r_frame_err;

endmodule : mdio_responder

`default_nettype wire

// File: tb/tb_mdio_responder.sv
// ============================================================================
// tb_mdio_responder : bit-banged MDIO master with queue-based scoreboard
// Rev 1.0           : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mdio_responder;
   import mdio_pkg::*;

   localparam int HALF   = 50;
   localparam int EV_WR  = 0;
   localparam int EV_RD  = 1;
   localparam int EV_ERR = 2;

   typedef struct {
      int          kind;
      logic [4:0]  addr;
      logic [15:0] data;
   } ev_t;

   typedef struct {
      string       name;
      logic [31:0] act;
      logic [31:0] exp;
   } pt_t;

   logic        clk  = 1'b0;
   logic        rst  = 1'b1;
   logic        mdc  = 1'b0;
   logic        m_oe = 1'b1;
   logic        m_bit = 1'b1;
   logic        done = 1'b0;
   logic        fin  = 1'b0;
   logic        mdio_i;
   logic        mdio_o, mdio_t, reg_rd, reg_wr, frame_err;
   logic [4:0]  reg_addr;
   logic [15:0] reg_rdata, reg_wdata;
   logic [15:0] regfile [32];

   int checks = 0;
   int errors = 0;

   ev_t         exp_q[$];
   logic [15:0] rdexp_q[$];
   logic [15:0] cap_q[$];
   pt_t         pt_q[$];

   // Open-drain style bus with pull-up when nobody drives
   assign mdio_i    = m_oe ? m_bit : (mdio_t ? 1'b1 : mdio_o);
   assign reg_rdata = regfile[reg_addr];

   always #5 clk = ~clk;

   mdio_responder #(
      .PHY_ADDR    (5'd1),
      .PRE_LEN     (32),
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mdc       (mdc),
      .mdio_i    (mdio_i),
      .mdio_o    (mdio_o),
      .mdio_t    (mdio_t),
      .reg_addr  (reg_addr),
      .reg_rd    (reg_rd),
      .reg_rdata (reg_rdata),
      .reg_wr    (reg_wr),
      .reg_wdata (reg_wdata),
      .frame_err (frame_err)
   );

   // ---------------- monitor / scoreboard ----------------
   task automatic score(input bit ok, input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      ev_t         e;
      pt_t         p;
      int          kind;
      logic [15:0] c;
      logic [15:0] x;
      if (reg_rd && reg_wr) score(1'b0, "rd_wr_overlap", 32'd1, 32'd0);
      if (reg_wr || reg_rd || frame_err) begin
         kind = reg_wr ? EV_WR : (reg_rd ? EV_RD : EV_ERR);
         if (exp_q.size() == 0) begin
            score(1'b0, "unexpected_strobe", 32'(kind), 32'hFF);
         end else begin
            e = exp_q.pop_front();
            score((e.kind == kind) && (kind == EV_ERR || e.addr == reg_addr)
                  && (kind != EV_WR || e.data == reg_wdata), "strobe",
                  {8'(kind), 3'b0, (kind == EV_ERR) ? 5'd0 : reg_addr,
                   (kind == EV_WR) ? reg_wdata : 16'h0},
                  {8'(e.kind), 3'b0, (e.kind == EV_ERR) ? 5'd0 : e.addr,
                   (e.kind == EV_WR) ? e.data : 16'h0});
         end
      end
      while (cap_q.size() > 0) begin
         c = cap_q.pop_front();
         if (rdexp_q.size() == 0) begin
            score(1'b0, "unexpected_rdata", 32'(c), 32'hFFFFFFFF);
         end else begin
            x = rdexp_q.pop_front();
            score(c == x, "read_data", 32'(c), 32'(x));
         end
      end
      while (pt_q.size() > 0) begin
         p = pt_q.pop_front();
         score(p.act == p.exp, p.name, p.act, p.exp);
      end
      if (done && !fin) begin
         fin = 1'b1;
         score(exp_q.size() == 0, "missing_strobes", 32'(exp_q.size()), 32'd0);
         score(rdexp_q.size() == 0, "missing_rdata", 32'(rdexp_q.size()), 32'd0);
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- master / stimulus ----------------
   task automatic post(input string name, input logic [31:0] act, input logic [31:0] exp);
      pt_t p;
      p.name = name;
      p.act  = act;
      p.exp  = exp;
      pt_q.push_back(p);
   endtask

   task automatic mdc_bit(input logic drive, input logic b, output logic s, output logic t);
      mdc   = 1'b0;
      m_oe  = drive;
      m_bit = b;
      #(HALF);
      mdc = 1'b1;
      s   = mdio_i;
      t   = mdio_t;
      #(HALF);
   endtask

   task automatic frame(input int pre, input logic [1:0] st, input logic [1:0] op,
                        input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] wd,
                        input int data_bits, output logic [15:0] cap, output logic ta1_t,
                        output logic ta2_s, output logic ta2_t, output logic drove);
      logic        s, t;
      logic [13:0] hdr;
      hdr   = {st, op, phy, ra};
      cap   = '0;
      drove = 1'b0;
      ta1_t = 1'b1;
      ta2_s = 1'b1;
      ta2_t = 1'b1;
      for (int i = 0; i < pre; i++) mdc_bit(1'b1, 1'b1, s, t);
      for (int i = 13; i >= 0; i--) begin
         mdc_bit(1'b1, hdr[i], s, t);
         drove |= !t;
      end
      if (op == OP_READ) begin
         mdc_bit(1'b0, 1'b1, s, t);
         ta1_t = t;
         drove |= !t;
         mdc_bit(1'b0, 1'b1, s, t);
         ta2_s = s;
         ta2_t = t;
         drove |= !t;
         for (int i = 0; i < data_bits; i++) begin
            mdc_bit(1'b0, 1'b1, s, t);
            cap = {cap[14:0], s};
            drove |= !t;
         end
      end else begin
         mdc_bit(1'b1, 1'b1, s, t);
         mdc_bit(1'b1, 1'b0, s, t);
         for (int i = 15; i >= 0; i--) mdc_bit(1'b1, wd[i], s, t);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      logic [15:0] cap;
      logic        ta1_t, ta2_s, ta2_t, drove;
      for (int i = 0; i < 32; i++) regfile[i] = 16'hC000 | 16'(i);
      regfile[2] = 16'h0141;
      regfile[5] = 16'h8E17;

      idle(4);
      post("rst_mdio_t", 32'(mdio_t), 32'd1);
      post("rst_mdio_o", 32'(mdio_o), 32'd0);
      post("rst_reg_addr", 32'(reg_addr), 32'd0);
      post("rst_reg_wdata", 32'(reg_wdata), 32'd0);
      post("rst_strobes", 32'({reg_rd, reg_wr, frame_err}), 32'd0);
      rst = 1'b0;
      idle(4);

      // addressed write
      exp_q.push_back('{EV_WR, 5'd4, 16'hA5C3});
      frame(32, 2'b01, OP_WRITE, 5'd1, 5'd4, 16'hA5C3, 16, cap, ta1_t, ta2_s, ta2_t, drove);
      idle(10);
      post("wr_reg_addr", 32'(reg_addr), 32'd4);
      post("wr_hiz", 32'(mdio_t), 32'd1);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
      // back-to-back write with no preamble
      exp_q.push_back('{EV_WR, 5'd6, 16'h0F0F});
      frame(0, 2'b01, OP_WRITE, 5'd1, 5'd6, 16'h0F0F, 16, cap, ta1_t, ta2_s, ta2_t, drove);
      idle(10);
`else
      // 31-bit preamble is too short: ignored
      frame(31, 2'b01, OP_WRITE, 5'd1, 5'd7, 16'h1234, 16, cap, ta1_t, ta2_s, ta2_t, drove);
      idle(10);
      exp_q.push_back('{EV_WR, 5'd7, 16'h1234});
      frame(32, 2'b01, OP_WRITE, 5'd1, 5'd7, 16'h1234, 16, cap, ta1_t, ta2_s, ta2_t, drove);
      idle(10);
`endif

      // addressed read
      exp_q.push_back('{EV_RD, 5'd2, 16'h0});
      rdexp_q.push_back(16'h0141);
      frame(32, 2'b01, OP_READ, 5'd1, 5'd2, 16'h0, 16, cap, ta1_t, ta2_s, ta2_t, drove);
      cap_q.push_back(cap);
      post("ta1_hiz", 32'(ta1_t), 32'd1);
      post("ta2_line", 32'(ta2_s), 32'd0);
      post("ta2_driven", 32'(ta2_t), 32'd0);
      idle(10);
      post("rd_release", 32'(mdio_t), 32'd1);

      // read to another PHY: silent
      frame(32, 2'b01, OP_READ, 5'd3, 5'd2, 16'h0, 16, cap, ta1_t, ta2_s, ta2_t, drove);
      post("skip_hiz", 32'(drove), 32'd0);
      idle(10);

      exp_q.push_back('{EV_RD, 5'd5, 16'h0});
      rdexp_q.push_back(16'h8E17);
      frame(32, 2'b01, OP_READ, 5'd1, 5'd5, 16'h0, 16, cap, ta1_t, ta2_s, ta2_t, drove);
      cap_q.push_back(cap);
      idle(10);

      // malformed frames
      exp_q.push_back('{EV_ERR, 5'd0, 16'h0});
      frame(32, 2'b01, 2'b11, 5'd1, 5'd4, 16'h3C3C, 16, cap, ta1_t, ta2_s, ta2_t, drove);
      idle(10);
      exp_q.push_back('{EV_ERR, 5'd0, 16'h0});
      frame(32, 2'b00, OP_WRITE, 5'd1, 5'd4, 16'h3C3C, 16, cap, ta1_t, ta2_s, ta2_t, drove);
      idle(10);

      // reset in the middle of read data
      exp_q.push_back('{EV_RD, 5'd2, 16'h0});
      frame(32, 2'b01, OP_READ, 5'd1, 5'd2, 16'h0, 7, cap, ta1_t, ta2_s, ta2_t, drove);
      mdc   = 1'b0;
      m_oe  = 1'b1;
      m_bit = 1'b1;
      post("abort_driving", 32'(mdio_t), 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      post("abort_hiz", 32'(mdio_t), 32'd1);
      idle(3);
      rst = 1'b0;
      idle(6);

      exp_q.push_back('{EV_RD, 5'd2, 16'h0});
      rdexp_q.push_back(16'h0141);
      frame(32, 2'b01, OP_READ, 5'd1, 5'd2, 16'h0, 16, cap, ta1_t, ta2_s, ta2_t, drove);
      cap_q.push_back(cap);
      idle(10);
      exp_q.push_back('{EV_WR, 5'd9, 16'h5AA5});
      frame(32, 2'b01, OP_WRITE, 5'd1, 5'd9, 16'h5AA5, 16, cap, ta1_t, ta2_s, ta2_t, drove);
      idle(10);
      post("final_hiz", 32'(mdio_t), 32'd1);

      idle(4);
      done = 1'b1;
   end

endmodule : tb_mdio_responder

`default_nettype wire
